// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores draining to data memory.
// Define STORE_FWD_EN to enable store-to-load forwarding of word stores.
module store_buffer #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDRESS_WIDTH-1:0]   alu_result,
    input  logic [DATA_WIDTH-1:0]      wd,
    input  logic [2:0]                 memcontrol,
    output logic                       stall,
    output logic                       mem_we,
    output logic [ADDRESS_WIDTH-1:0]   mem_a,
    output logic [DATA_WIDTH-1:0]      mem_wd,
    output logic [2:0]                 mem_memcontrol,
    input  logic                       mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]   ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [2:0]               mc_q   [DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;
    logic          full, push, pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign push  = we && !full;
    assign pop   = mem_we && mem_ready;
    assign stall = we && full;
    // cnt_q is already 0 under reset, so gate empty to keep outputs low.
    assign empty = rst && (cnt_q == '0);
    assign count = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            if (push && !pop)
                cnt_q <= cnt_q + 1'b1;
            else if (pop && !push)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= alu_result;
            data_q[tail_q] <= wd;
            mc_q[tail_q]   <= memcontrol;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = DRAIN;
            end
            DRAIN: begin
                mem_we = 1'b1;
                if (mem_ready && !push && cnt_q == CW'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_a          = mem_we ? addr_q[head_q] : '0;
    assign mem_wd         = mem_we ? data_q[head_q] : '0;
    assign mem_memcontrol = mem_we ? mc_q[head_q]   : '0;

`ifdef STORE_FWD_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < cnt_q && mc_q[idx] == 3'b010 &&
                addr_q[idx][ADDRESS_WIDTH-1:2] ==
                ld_addr[ADDRESS_WIDTH-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard testbench for store_buffer: expected stores are queued on
// acceptance and compared as the buffer presents them to memory.
module tb_store_buffer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    mc;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] alu_result = '0;
    logic [DW-1:0] wd = '0;
    logic [2:0]    memcontrol = '0;
    logic          stall;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [2:0]    mem_memcontrol;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          empty;
    logic [CW-1:0] count;

    int   vectors = 0;
    int   errs = 0;
    int   mcnt = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    store_buffer #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .alu_result(alu_result),
        .wd(wd),
        .memcontrol(memcontrol),
        .stall(stall),
        .mem_we(mem_we),
        .mem_a(mem_a),
        .mem_wd(mem_wd),
        .mem_memcontrol(mem_memcontrol),
        .mem_ready(mem_ready),
        .ld_addr(ld_addr),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data),
        .empty(empty),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Monitor: sampled at the falling edge, inputs are stable here.
    always @(negedge clk) begin
        logic          hit;
        logic [DW-1:0] fd;
        logic          push, pop;
        ent_t          e;
        if (!rst) begin
            chk("rst_mem_we", 64'(mem_we), 0);
            chk("rst_count", 64'(count), 0);
            chk("rst_empty", 64'(empty), 0);
            chk("rst_stall", 64'(stall), 0);
            chk("rst_fwd", 64'(fwd_hit), 0);
            q.delete();
            mcnt = 0;
        end else begin
            hit = 1'b0;
            fd  = '0;
            foreach (q[i])
                if (q[i].mc == 3'b010 && q[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
                    hit = 1'b1;
                    fd  = q[i].d;
                end
`ifndef STORE_FWD_EN
            hit = 1'b0;
            fd  = '0;
`endif
            chk("count", 64'(count), 64'(mcnt));
            chk("empty", 64'(empty), 64'(mcnt == 0));
            chk("mem_we", 64'(mem_we), 64'(mcnt != 0));
            chk("stall", 64'(stall), 64'(we && mcnt == DEPTH));
            chk("fwd_hit", 64'(fwd_hit), 64'(hit));
            chk("fwd_data", 64'(fwd_data), 64'(fd));
            pop  = (mcnt != 0) && mem_ready;
            push = we && (mcnt < DEPTH);
            if (mcnt != 0 && q.size() != 0) begin
                e = q[0];
                chk("mem_a", 64'(mem_a), 64'(e.a));
                chk("mem_wd", 64'(mem_wd), 64'(e.d));
                chk("mem_mc", 64'(mem_memcontrol), 64'(e.mc));
            end else begin
                chk("idle_mem_a", 64'(mem_a), 0);
                chk("idle_mem_wd", 64'(mem_wd), 0);
            end
            if (pop && q.size() != 0) void'(q.pop_front());
            if (push) q.push_back('{alu_result, wd, memcontrol});
            mcnt = mcnt + int'(push) - int'(pop);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [2:0] mc);
        we         = 1'b1;
        alu_result = a;
        wd         = d;
        memcontrol = mc;
        cyc();
        we = 1'b0;
    endtask

    task automatic drain();
        int n;
        we        = 1'b0;
        mem_ready = 1'b1;
        n = 0;
        while (!empty && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 64'(empty), 1);
        cyc();
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;
        cyc();

        // Single store, memory ready.
        mem_ready = 1'b1;
        store(32'h100, 32'hDEADBEEF, 3'b010);
        cyc(2);
        chk("single_empty", 64'(empty), 1);

        // Fill with memory stalled; fifth store is rejected.
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) store(32'h10 + 32'(4 * i), $urandom, 3'b010);
        chk("full_count", 64'(count), 4);
        drain();

        // Simultaneous push and pop at count 2.
        mem_ready = 1'b0;
        store(32'h40, 32'hA1, 3'b010);
        store(32'h44, 32'hA2, 3'b001);
        mem_ready = 1'b1;
        store(32'h48, 32'hA3, 3'b010);
        mem_ready = 1'b0;
        chk("pushpop_count", 64'(count), 2);
        drain();

        // Forwarding lookups, including a byte store that must not hit.
        mem_ready = 1'b0;
        store(32'h200, 32'h11, 3'b010);
        store(32'h200, 32'h22, 3'b010);
        store(32'h300, 32'h33, 3'b000);
        ld_addr = 32'h202;
        cyc();
`ifdef STORE_FWD_EN
        chk("fwd_202_hit", 64'(fwd_hit), 1);
        chk("fwd_202_data", 64'(fwd_data), 32'h22);
`endif
        ld_addr = 32'h204;
        cyc();
        chk("fwd_204_hit", 64'(fwd_hit), 0);
        ld_addr = 32'h300;
        cyc();
        chk("fwd_300_hit", 64'(fwd_hit), 0);
        drain();

        // Reset between edges while draining.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h500 + 32'(4 * i), $urandom, 3'b010);
        rst = 1'b0;
        #1;
        chk("async_mem_we", 64'(mem_we), 0);
        chk("async_count", 64'(count), 0);
        cyc();
        rst = 1'b1;
        mem_ready = 1'b1;
        cyc(3);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            we         = 1'($urandom_range(0, 1));
            mem_ready  = ($urandom_range(0, 3) != 0);
            alu_result = 32'h200 + 32'($urandom_range(0, 7) * 2);
            wd         = $urandom;
            memcontrol = 3'($urandom_range(0, 2));
            ld_addr    = 32'h200 + 32'($urandom_range(0, 7) * 2);
            cyc();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
